// File: rtl/alu_selftest.sv
// Self-checking stimulus/check engine for ALU blocks: LFSR operands,
// round-robin opcodes, latency-aligned golden compare and error capture.
module alu_selftest #(
    parameter int          WIDTH   = 16,
    parameter int          N_VEC   = 64,
    parameter int          LATENCY = 1,
    parameter logic [31:0] SEED    = 32'h0000_0001,
    parameter int          ERR_W   = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_run,
    output logic                     o_running,
    output logic                     o_done,
    output logic                     o_passed,
    output logic [2:0]               o_op,
    output logic [WIDTH-1:0]         o_arg0,
    output logic [WIDTH-1:0]         o_arg1,
    input  logic [WIDTH-1:0]         i_data,
    output logic [ERR_W-1:0]         o_err_count,
    output logic [$clog2(N_VEC):0]   o_fail_index
);

    localparam int              FI_W = $clog2(N_VEC) + 1;
    localparam logic [31:0]     MASK = 32'h8020_0003;
    localparam logic [FI_W-1:0] LAST = FI_W'(N_VEC - 1);
    localparam logic [2:0]      DLAT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_n;
    logic [31:0]       lfsr, lfsr_n;
    logic [FI_W-1:0]   idx, idx_n;
    logic [2:0]        dcnt;
    logic              last;
    logic              start;

    logic              iv;
    logic [WIDTH-1:0]  ie;
    logic              cv;
    logic [WIDTH-1:0]  ce;
    logic [FI_W-1:0]   ci;
    logic              cmp_en;

    function automatic logic [WIDTH-1:0] golden(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        r = '0;
        unique case (op)
            3'd0: r = ~a;
            3'd1: r = a & b;
            3'd2: r = a | b;
            3'd3: r = a ^ b;
            3'd4: r = a + b;
            3'd5: r = a - b;
            3'd6: r = {a[WIDTH-2:0], 1'b0};
            3'd7: r = {a[WIDTH-1], a[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    assign lfsr_n = lfsr[0] ? ((lfsr >> 1) ^ MASK) : (lfsr >> 1);
    assign idx_n  = idx + FI_W'(1);
    assign last   = (idx == LAST);
    assign start  = (state == IDLE) && i_run;

    // FSM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (i_run) state_n = RUN;
            RUN: begin
                if (!i_run)    state_n = IDLE;
                else if (last) state_n = (LATENCY == 0) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (!i_run)         state_n = IDLE;
                else if (dcnt == 0) state_n = DONE;
            end
            DONE:  if (!i_run) state_n = IDLE;
        endcase
    end

    // Issue stage: outputs always show the vector being issued
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr   <= SEED;
            idx    <= '0;
            o_op   <= '0;
            o_arg0 <= '0;
            o_arg1 <= '0;
            dcnt   <= '0;
        end else begin
            if (start) begin
                lfsr   <= SEED;
                idx    <= '0;
                o_op   <= '0;
                o_arg0 <= SEED[WIDTH-1:0];
                o_arg1 <= SEED[31 -: WIDTH];
            end else if (state == RUN && i_run && !last) begin
                lfsr   <= lfsr_n;
                idx    <= idx_n;
                o_op   <= idx_n[2:0];
                o_arg0 <= lfsr_n[WIDTH-1:0];
                o_arg1 <= lfsr_n[31 -: WIDTH];
            end
            if (state == RUN)
                dcnt <= DLAT;
            else if (state == DRAIN && dcnt != 0)
                dcnt <= dcnt - 3'd1;
        end
    end

    assign iv = (state == RUN);
    assign ie = golden(o_op, o_arg0, o_arg1);

    generate
        if (LATENCY == 0) begin : g_nolat
            assign cv = iv;
            assign ce = ie;
            assign ci = idx;
        end else begin : g_lat
            logic             pv [LATENCY];
            logic [WIDTH-1:0] pe [LATENCY];
            logic [FI_W-1:0]  pi [LATENCY];

            // Flushed while idle so an aborted run leaves nothing in flight
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int k = 0; k < LATENCY; k++) begin
                        pv[k] <= 1'b0;
                        pe[k] <= '0;
                        pi[k] <= '0;
                    end
                end else begin
                    pv[0] <= iv && (state != IDLE);
                    pe[0] <= ie;
                    pi[0] <= idx;
                    for (int k = 1; k < LATENCY; k++) begin
                        pv[k] <= pv[k-1] && (state != IDLE);
                        pe[k] <= pe[k-1];
                        pi[k] <= pi[k-1];
                    end
                end
            end

            assign cv = pv[LATENCY-1];
            assign ce = pe[LATENCY-1];
            assign ci = pi[LATENCY-1];
        end
    endgenerate

    assign cmp_en = cv && i_run && (state == RUN || state == DRAIN);

    // Results persist until the next run starts
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err_count  <= '0;
            o_fail_index <= '1;
        end else if (start) begin
            o_err_count  <= '0;
            o_fail_index <= '1;
        end else if (cmp_en && (i_data != ce)) begin
            if (o_err_count != '1)
                o_err_count <= o_err_count + ERR_W'(1);
            if (o_err_count == '0)
                o_fail_index <= ci;
        end
    end

    assign o_running = (state == RUN) || (state == DRAIN);
    assign o_done    = (state == DONE);
    assign o_passed  = (state == DONE) && (o_err_count == '0);

endmodule

// File: tb/tb_alu_selftest.sv
// Directed bench for alu_selftest: reset, first vectors, clean/faulty runs,
// abort/rerun, latency alignment and a 32-bit build.
module tb_alu_selftest;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic run;
    logic run_x;
    logic inject;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic [31:0] ref_alu(
        input logic [2:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input int          w
    );
        logic [31:0] m;
        logic [31:0] r;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case (op)
            3'd0:    r = ~a;
            3'd1:    r = a & b;
            3'd2:    r = a | b;
            3'd3:    r = a ^ b;
            3'd4:    r = a + b;
            3'd5:    r = a - b;
            3'd6:    r = a << 1;
            default: r = (a >> 1) | (32'(a[w-1]) << (w - 1));
        endcase
        return r & m;
    endfunction

    // Main 8-bit, latency-1 instance with fault injection on its model
    logic       m_running, m_done, m_passed;
    logic [2:0] m_op;
    logic [7:0] m_a0, m_a1;
    logic [7:0] m_data = '0;
    logic [7:0] m_err;
    logic [4:0] m_fi;
    int         vcnt = 0;

    alu_selftest #(.WIDTH(8), .N_VEC(16), .LATENCY(1),
                   .SEED(32'h1), .ERR_W(8)) u_main (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run),
        .o_running(m_running), .o_done(m_done), .o_passed(m_passed),
        .o_op(m_op), .o_arg0(m_a0), .o_arg1(m_a1), .i_data(m_data),
        .o_err_count(m_err), .o_fail_index(m_fi)
    );

    always @(posedge clk) begin
        vcnt   <= m_running ? vcnt + 1 : 0;
        m_data <= 8'(ref_alu(m_op, 32'(m_a0), 32'(m_a1), 8))
                  ^ {7'd0, inject && (vcnt == 5 || vcnt == 9)};
    end

    // Latency-3 engine against a 3-stage ALU
    logic       l3_running, l3_done, l3_passed;
    logic [2:0] l3_op;
    logic [7:0] l3_a0, l3_a1;
    logic [7:0] l3_d1 = '0, l3_d2 = '0, l3_d3 = '0;
    logic [7:0] l3_err;
    logic [4:0] l3_fi;

    alu_selftest #(.WIDTH(8), .N_VEC(16), .LATENCY(3),
                   .SEED(32'h1), .ERR_W(8)) u_l3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run_x),
        .o_running(l3_running), .o_done(l3_done), .o_passed(l3_passed),
        .o_op(l3_op), .o_arg0(l3_a0), .o_arg1(l3_a1), .i_data(l3_d3),
        .o_err_count(l3_err), .o_fail_index(l3_fi)
    );

    always @(posedge clk) begin
        l3_d1 <= 8'(ref_alu(l3_op, 32'(l3_a0), 32'(l3_a1), 8));
        l3_d2 <= l3_d1;
        l3_d3 <= l3_d2;
    end

    // Latency-2 engine against the same 3-stage ALU: misaligned
    logic       l2_running, l2_done, l2_passed;
    logic [2:0] l2_op;
    logic [7:0] l2_a0, l2_a1;
    logic [7:0] l2_d1 = '0, l2_d2 = '0, l2_d3 = '0;
    logic [7:0] l2_err;
    logic [4:0] l2_fi;

    alu_selftest #(.WIDTH(8), .N_VEC(16), .LATENCY(2),
                   .SEED(32'h1), .ERR_W(8)) u_l2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run_x),
        .o_running(l2_running), .o_done(l2_done), .o_passed(l2_passed),
        .o_op(l2_op), .o_arg0(l2_a0), .o_arg1(l2_a1), .i_data(l2_d3),
        .o_err_count(l2_err), .o_fail_index(l2_fi)
    );

    always @(posedge clk) begin
        l2_d1 <= 8'(ref_alu(l2_op, 32'(l2_a0), 32'(l2_a1), 8));
        l2_d2 <= l2_d1;
        l2_d3 <= l2_d2;
    end

    // 32-bit build, latency 1
    logic        w_running, w_done, w_passed;
    logic [2:0]  w_op;
    logic [31:0] w_a0, w_a1;
    logic [31:0] w_data = '0;
    logic [7:0]  w_err;
    logic [4:0]  w_fi;

    alu_selftest #(.WIDTH(32), .N_VEC(16), .LATENCY(1),
                   .SEED(32'h1), .ERR_W(8)) u_w32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run_x),
        .o_running(w_running), .o_done(w_done), .o_passed(w_passed),
        .o_op(w_op), .o_arg0(w_a0), .o_arg1(w_a1), .i_data(w_data),
        .o_err_count(w_err), .o_fail_index(w_fi)
    );

    always @(posedge clk)
        w_data <= ref_alu(w_op, w_a0, w_a1, 32);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt;
        rst_n  = 1'b0;
        run    = 1'b1;
        run_x  = 1'b0;
        inject = 1'b0;
        repeat (2) tick();

        chk("rst_running", 32'(m_running), 32'd0);
        chk("rst_done",    32'(m_done),    32'd0);
        chk("rst_passed",  32'(m_passed),  32'd0);
        chk("rst_op",      32'(m_op),      32'd0);
        chk("rst_arg0",    32'(m_a0),      32'd0);
        chk("rst_arg1",    32'(m_a1),      32'd0);
        chk("rst_err",     32'(m_err),     32'd0);
        chk("rst_fidx",    32'(m_fi),      32'h1F);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("v0_running", 32'(m_running), 32'd1);
        chk("v0_op",      32'(m_op),      32'd0);
        chk("v0_arg0",    32'(m_a0),      32'h01);
        chk("v0_arg1",    32'(m_a1),      32'h00);
        tick();
        chk("v1_op",      32'(m_op),      32'd1);
        chk("v1_arg0",    32'(m_a0),      32'h03);
        chk("v1_arg1",    32'(m_a1),      32'h80);

        cnt = 2;
        while (m_running && cnt < 40) begin
            tick();
            if (m_running) cnt++;
        end
        chk("clean_run_len", 32'(cnt),      32'd17);
        chk("clean_done",    32'(m_done),   32'd1);
        chk("clean_passed",  32'(m_passed), 32'd1);
        chk("clean_err",     32'(m_err),    32'd0);
        chk("clean_fidx",    32'(m_fi),     32'h1F);

        // Corrupt vectors 5 and 9
        run = 1'b0;
        tick();
        chk("idle_done", 32'(m_done), 32'd0);
        inject = 1'b1;
        run    = 1'b1;
        tick();
        cnt = 0;
        while (!m_done && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("fault_done",    32'(m_done),    32'd1);
        chk("fault_err",     32'(m_err),     32'd2);
        chk("fault_fidx",    32'(m_fi),      32'd5);
        chk("fault_passed",  32'(m_passed),  32'd0);
        chk("fault_running", 32'(m_running), 32'd0);

        // Abort after vector 7, then rerun
        inject = 1'b0;
        run    = 1'b0;
        tick();
        run = 1'b1;
        tick();
        repeat (7) tick();
        chk("abort_v7_op", 32'(m_op), 32'd7);
        run = 1'b0;
        tick();
        chk("abort_running", 32'(m_running), 32'd0);
        chk("abort_passed",  32'(m_passed),  32'd0);
        chk("abort_done",    32'(m_done),    32'd0);
        chk("abort_err",     32'(m_err),     32'd0);
        run = 1'b1;
        tick();
        chk("rerun_running", 32'(m_running), 32'd1);
        chk("rerun_op",      32'(m_op),      32'd0);
        chk("rerun_arg0",    32'(m_a0),      32'h01);
        cnt = 0;
        while (!m_done && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("rerun_done",   32'(m_done),   32'd1);
        chk("rerun_passed", 32'(m_passed), 32'd1);
        chk("rerun_err",    32'(m_err),    32'd0);

        // Latency alignment and wide build
        run_x = 1'b1;
        cnt = 0;
        while (!(l3_done && l2_done && w_done) && cnt < 60) begin
            tick();
            cnt++;
        end
        chk("l3_done",    32'(l3_done),       32'd1);
        chk("l3_passed",  32'(l3_passed),     32'd1);
        chk("l3_err",     32'(l3_err),        32'd0);
        chk("l2_done",    32'(l2_done),       32'd1);
        chk("l2_err_nz",  32'(l2_err != 8'd0), 32'd1);
        chk("l2_passed",  32'(l2_passed),     32'd0);
        chk("w32_done",   32'(w_done),        32'd1);
        chk("w32_passed", 32'(w_passed),      32'd1);
        chk("w32_fidx",   32'(w_fi),          32'h1F);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_selftest.md
Name: alu_selftest

Overview:
- Parametrised, self-checking stimulus and check engine for ALU blocks on the FPGA.
- Generalises the fixed 8/16-bit ALU test fixtures to any WIDTH from 4 to 32, a configurable vector count and a configurable DUT pipeline latency.
- Drives pseudo-random operands plus round-robin opcodes into a DUT and compares each result against an internal golden model.
- Counts mismatches, records the first failing vector, and reports running/done/passed to the top level (LED or bench).

Parameters:
- WIDTH, 16: ALU data width; legal range 4..32.
- N_VEC, 64: number of vectors issued per run; minimum 8.
- LATENCY, 1: DUT cycles from o_op/o_arg* to a valid i_data; legal range 0..7.
- SEED, 32'h0000_0001: LFSR reload value; must be nonzero.
- ERR_W, 8: width of the error counter.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous reset, active low
- i_run  in  1  level: high starts or holds a run; low aborts or re-arms
- o_running  out  1  high in RUN and DRAIN
- o_done  out  1  high in DONE
- o_passed  out  1  high in DONE only when o_err_count==0
- o_op  out  3  opcode to DUT
- o_arg0  out  WIDTH  operand A to DUT
- o_arg1  out  WIDTH  operand B to DUT
- i_data  in  WIDTH  DUT result
- o_err_count  out  ERR_W  mismatch count; saturates at all-ones
- o_fail_index  out  $clog2(N_VEC)+1  index of first mismatch; all-ones if none

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; LFSR=SEED; vector index=0.
  - o_op, o_arg0, o_arg1 = 0; o_running, o_done, o_passed = 0.
  - o_err_count=0; o_fail_index=all-ones.
  - Valid pipeline cleared.
- Opcodes (golden model, result truncated to WIDTH):
  - 0 NOT ~A; 1 AND; 2 OR; 3 XOR.
  - 4 ADD A+B; 5 SUB A-B (both mod 2^WIDTH).
  - 6 LSL1 A<<1; 7 ASR1 arithmetic A>>1 (MSB replicated).
- Stimulus, per issue cycle:
  - op = index[2:0].
  - arg0 = lfsr[WIDTH-1:0].
  - arg1 = lfsr[31 -: WIDTH].
  - Then index+1 and LFSR advances one step: Galois, polynomial x^32+x^22+x^2+x+1, mask 32'h8020_0003, shift right, XOR mask when the LSB is 1.
- Check pipeline:
  - Expected value and a valid bit are delayed LATENCY cycles and aligned with i_data.
  - On valid, compare full WIDTH.
  - On mismatch: increment o_err_count (saturating).
  - On the first mismatch of a run only: latch the issuing index into o_fail_index.
  - LATENCY=0 compares combinationally in the issue cycle.
- FSM:
  - IDLE: i_run high -> RUN. On entry: clear counters, o_fail_index=all-ones, LFSR=SEED, index=0.
  - RUN: issues one vector every cycle, indices 0..N_VEC-1. After the last issue -> DRAIN; outputs hold the last vector.
  - DRAIN: waits LATENCY cycles for outstanding compares, then -> DONE. With LATENCY=0, RUN goes directly to DONE.
  - DONE: o_done=1; o_passed=(o_err_count==0). Holds while i_run is high. i_run low -> IDLE; results are retained until the next run starts.
- Abort: i_run low in RUN or DRAIN -> IDLE next cycle.
  - In-flight compares are discarded.
  - o_passed stays 0; counters keep partial values.
  - The next run restarts from SEED, index 0.
- Timing:
  - o_running rises the cycle after i_run is sampled high in IDLE.
  - Total run length is N_VEC+LATENCY cycles from RUN entry to DONE entry.
- Async reset mid-run returns everything to the reset values.

Test Plan:
- Reset: hold i_rst_n=0 with i_run=1 -> all outputs 0; o_fail_index=all-ones. Release -> RUN starts the next cycle.
- First vector: WIDTH=8, SEED=1 -> vector 0 is op=0, arg0=8'h01, arg1=8'h00, expected 8'hFE. Vector 1 is op=1 with arg0=8'h03 (LFSR 32'h8020_0003).
- Clean pass: WIDTH=8, N_VEC=16, LATENCY=1, with a correct ALU model as DUT.
  - i_run rises at cycle 3 -> o_running for 17 cycles.
  - Then o_done=1, o_passed=1, o_err_count=0, o_fail_index=5'h1F.
- Fault injection: bench corrupts DUT output only for vectors 5 and 9 -> o_err_count=2, o_fail_index=5, o_passed=0, o_done=1.
- Abort and rerun: drop i_run after vector 7 issues -> IDLE next cycle, o_running=0, o_passed=0. Re-raise i_run -> vector 0 again has arg0=8'h01; the run completes and passes.
- Latency mismatch: LATENCY=3 with a 3-stage DUT -> pass. The same DUT with LATENCY=2 -> o_err_count>0; WIDTH=32 build passes with a correct DUT.
